cnn_result_collector: RTL and testbench



---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_stability_detector.sv | 67 ++++++
 rtl/cnn_result_collector.sv | 166 ++++++++++++++++
 tb/tb_cnn_result_collector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result collector.
package cnn_pkg;

   localparam int CNN_WIDTH  = 9;
   localparam int Y_W        = 2 * CNN_WIDTH;
   localparam int N_CELLS    = 16;
   localparam int ONE_Q8     = 256;
   localparam int NEG_ONE_Q8 = -256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2
   } state_t;

endpackage

// File: rtl/cnn_stability_detector.sv
// Tracks the 16 array outputs in a snapshot register and counts consecutive
// unchanged cycles; asserts stable once the count reaches STABLE_CYCLES.
module cnn_stability_detector
   import cnn_pkg::*;
#(
   parameter int WIDTH         = 9,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         track,
   input  logic [N_CELLS*2*WIDTH-1:0]   y_in,
   output logic [N_CELLS*2*WIDTH-1:0]   snapshot,
   output logic [N_CELLS*2*WIDTH-1:0]   snap_next,
   output logic                         stable
);

   localparam int TOT = N_CELLS * 2 * WIDTH;
   localparam int SW  = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);

   logic [TOT-1:0] snap_r;
   logic [SW-1:0]  stable_cnt_r;
   logic [SW-1:0]  stable_cnt_next_s;
   logic           same_s;

   // Next snapshot and saturating stable count
   always_comb begin
      same_s            = (y_in == snap_r);
      snap_next         = snap_r;
      stable_cnt_next_s = stable_cnt_r;
      if (load) begin
         snap_next         = y_in;
         stable_cnt_next_s = {SW{1'b0}};
      end else if (track) begin
         if (same_s) begin
            if (stable_cnt_r != STABLE_MAX) begin
               stable_cnt_next_s = stable_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
               stable_cnt_next_s = stable_cnt_r;
            end
         end else begin
            snap_next         = y_in;
            stable_cnt_next_s = {SW{1'b0}};
         end
      end else begin
         snap_next         = snap_r;
         stable_cnt_next_s = stable_cnt_r;
      end
   end

   // Snapshot and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_r       <= {TOT{1'b0}};
         stable_cnt_r <= {SW{1'b0}};
      end else begin
         snap_r       <= snap_next;
         stable_cnt_r <= stable_cnt_next_s;
      end
   end

   assign snapshot = snap_r;
   assign stable   = (stable_cnt_r >= STABLE_MAX);

endmodule

// File: rtl/cnn_result_collector.sv
// Waits for the 4x4 array outputs to settle (or time out), then streams the
// 16 snapshot words over valid/ready. CNN_COLLECT_BINARIZE_EN sign-quantizes out_data.
module cnn_result_collector
   import cnn_pkg::*;
#(
   parameter int WIDTH         = 9,
   parameter int STABLE_CYCLES = 8,
   parameter int MAX_CYCLES    = 1023
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [N_CELLS*2*WIDTH-1:0]   y_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*WIDTH-1:0]           out_data,
   output logic [3:0]                   out_idx,
   output logic                         out_last,
   output logic                         busy,
   output logic                         timed_out
);

   localparam int YW  = 2 * WIDTH;
   localparam int TOT = N_CELLS * YW;
   localparam int CW  = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] CYC_MAX   = CW'(MAX_CYCLES);
   localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYCLES - 1);
   localparam logic [YW-1:0] ONE_W     = YW'(ONE_Q8);
   localparam logic [YW-1:0] NEG_ONE_W = YW'(NEG_ONE_Q8);

   state_t          state_r;
   state_t          next_s;
   logic [CW-1:0]   cycle_cnt_r;
   logic [TOT-1:0]  snapshot_s;
   logic [TOT-1:0]  snap_next_s;
   logic            stable_s;
   logic            timeout_s;
   logic            xfer_s;
   logic [3:0]      idx_inc_s;
   logic            valid_r;
   logic [YW-1:0]   data_r;
   logic [3:0]      idx_r;
   logic            last_r;
   logic            busy_r;
   logic            timed_out_r;

   function automatic logic [YW-1:0] cell_word(input logic [TOT-1:0] v, input logic [3:0] k);
      logic [YW-1:0] w;
      w = v[int'(k)*YW +: YW];
`ifdef CNN_COLLECT_BINARIZE_EN
      return w[YW-1] ? NEG_ONE_W : ONE_W;
`else
      return w;
`endif
   endfunction

   cnn_stability_detector #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_detect (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      ((state_r == IDLE) && start),
      .track     (state_r == SETTLE),
      .y_in      (y_in),
      .snapshot  (snapshot_s),
      .snap_next (snap_next_s),
      .stable    (stable_s)
   );

   assign timeout_s = (state_r == SETTLE) && (cycle_cnt_r >= CYC_LIMIT);
   assign xfer_s    = valid_r && out_ready;
   assign idx_inc_s = idx_r + 4'd1;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; convergence takes priority over timeout
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = SETTLE;
            else       next_s = IDLE;
         end
         SETTLE: begin
            if (stable_s || timeout_s) next_s = SEND;
            else                       next_s = SETTLE;
         end
         SEND: begin
            if (xfer_s && (idx_r == 4'd15)) next_s = IDLE;
            else                            next_s = SEND;
         end
         default: next_s = IDLE;
      endcase
   end

   // Timeout counter, status flags and output word registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_cnt_r <= {CW{1'b0}};
         valid_r     <= 1'b0;
         data_r      <= {YW{1'b0}};
         idx_r       <= 4'd0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         timed_out_r <= 1'b0;
      end else begin
         busy_r <= (next_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  cycle_cnt_r <= {CW{1'b0}};
                  timed_out_r <= 1'b0;
               end
            end
            SETTLE: begin
               if (cycle_cnt_r != CYC_MAX) begin
                  cycle_cnt_r <= cycle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
               if (stable_s || timeout_s) begin
                  timed_out_r <= !stable_s;
                  valid_r     <= 1'b1;
                  idx_r       <= 4'd0;
                  last_r      <= 1'b0;
                  data_r      <= cell_word(snap_next_s, 4'd0);
               end
            end
            SEND: begin
               if (xfer_s) begin
                  if (idx_r == 4'd15) begin
                     valid_r <= 1'b0;
                     idx_r   <= 4'd0;
                     last_r  <= 1'b0;
                     data_r  <= {YW{1'b0}};
                  end else begin
                     idx_r  <= idx_inc_s;
                     last_r <= (idx_inc_s == 4'd15);
                     data_r <= cell_word(snapshot_s, idx_inc_s);
                  end
               end
            end
            default: begin
               valid_r <= 1'b0;
               idx_r   <= 4'd0;
               last_r  <= 1'b0;
               data_r  <= {YW{1'b0}};
            end
         endcase
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign out_idx   = idx_r;
   assign out_last  = last_r;
   assign busy      = busy_r;
   assign timed_out = timed_out_r;

endmodule

// File: tb/tb_cnn_result_collector.sv
// Directed self-checking bench for cnn_result_collector (STABLE_CYCLES=8, MAX_CYCLES=50).
module tb_cnn_result_collector;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [287:0] y_in;
   logic         out_valid;
   logic         out_ready;
   logic [17:0]  out_data;
   logic [3:0]   out_idx;
   logic         out_last;
   logic         busy;
   logic         timed_out;

   int vecs = 0;
   int errs = 0;

   logic [287:0] p1, p2, p3, p4, pt;
   logic [17:0]  ya, yb;

   cnn_result_collector #(
      .WIDTH         (9),
      .STABLE_CYCLES (8),
      .MAX_CYCLES    (50)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .timed_out (timed_out)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] expw(input logic [287:0] s, input int k);
      logic [17:0] w;
      w = s[k*18 +: 18];
`ifdef CNN_COLLECT_BINARIZE_EN
      return w[17] ? 18'h3FF00 : 18'h00100;
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [287:0] y);
      y_in  = y;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("wait_valid", {31'd0, out_valid}, 32'd1);
   endtask

   // act: 0 none, 1 start pulse + y_in change at act_at, 2 reset at act_at
   task automatic run_burst(input logic [287:0] snap, input int bp, input int act_at,
                            input int act, input logic [287:0] y_alt);
      int k, cyc;
      logic rdy;
      k = 0;
      cyc = 0;
      while (k < 16 && cyc < 100) begin
         rdy = (bp == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
         out_ready = rdy;
         chk("b_valid", {31'd0, out_valid}, 32'd1);
         chk("b_idx",   {28'd0, out_idx}, k);
         chk("b_data",  {14'd0, out_data}, {14'd0, expw(snap, k)});
         chk("b_last",  {31'd0, out_last}, (k == 15) ? 32'd1 : 32'd0);
         chk("b_busy",  {31'd0, busy}, 32'd1);
         if (k == act_at && act == 2) begin
            rst_n = 1'b0;
            tick();
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_busy",  {31'd0, busy}, 32'd0);
            chk("rst_idx",   {28'd0, out_idx}, 32'd0);
            rst_n = 1'b1;
            return;
         end
         if (k == act_at && act == 1) begin
            start = 1'b1;
            y_in  = y_alt;
         end
         tick();
         start = 1'b0;
         if (rdy) k++;
         cyc++;
      end
      chk("b_count", k, 32'd16);
      chk("b_end_valid", {31'd0, out_valid}, 32'd0);
      chk("b_end_busy",  {31'd0, busy}, 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         p1[k*18 +: 18] = (k == 5 || k == 6 || k == 9 || k == 10) ? 18'h00100 : 18'h3FF00;
         p2[k*18 +: 18] = 18'(k) * 18'h00111 + 18'h00001;
         p3[k*18 +: 18] = 18'h20000 | 18'(k);
         p4[k*18 +: 18] = 18'(k) * 18'h01000;
      end
      p4[0*18 +: 18] = 18'h3FC80;
      p4[1*18 +: 18] = 18'h00000;
      p4[2*18 +: 18] = 18'h00240;
      ya = 18'h12345;
      yb = 18'h00ABC;

      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      y_in = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data",  {14'd0, out_data}, 32'd0);
      chk("rst_idx",   {28'd0, out_idx}, 32'd0);
      chk("rst_last",  {31'd0, out_last}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_tout",  {31'd0, timed_out}, 32'd0);

      // Convergence: out_valid rises exactly 9 cycles after start
      out_ready = 1'b1;
      pulse_start(p1);
      chk("s1_busy", {31'd0, busy}, 32'd1);
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk("s1_quiet", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("s1_rise", {31'd0, out_valid}, 32'd1);
      chk("s1_tout", {31'd0, timed_out}, 32'd0);
      run_burst(p1, 0, -1, 0, p1);
      chk("s1_tout_end", {31'd0, timed_out}, 32'd0);

      // Timeout: Y1 toggles every 4 cycles, SEND after 50 cycles
      pt = p1;
      pulse_start(pt);
      for (int n = 1; n <= 50; n++) begin
         pt[17:0] = (((n + 2) >> 2) & 1) != 0 ? ya : yb;
         y_in = pt;
         chk("s2_quiet", {31'd0, out_valid}, 32'd0);
         tick();
      end
      chk("s2_rise", {31'd0, out_valid}, 32'd1);
      chk("s2_tout", {31'd0, timed_out}, 32'd1);
      run_burst(pt, 0, -1, 0, pt);
      chk("s2_sticky", {31'd0, timed_out}, 32'd1);

      // Backpressure 1,0,0,1
      pulse_start(p2);
      chk("s3_tout_clr", {31'd0, timed_out}, 32'd0);
      wait_valid();
      run_burst(p2, 1, -1, 0, p2);

      // start and y_in change mid-SEND do not disturb the burst
      pulse_start(p3);
      wait_valid();
      run_burst(p3, 0, 3, 1, p1);
      chk("s4_idle", {31'd0, busy}, 32'd0);

      // Reset at idx 7, then a fresh full burst
      pulse_start(p2);
      wait_valid();
      run_burst(p2, 0, 7, 2, p2);
      tick();
      chk("s5_idle_valid", {31'd0, out_valid}, 32'd0);
      pulse_start(p1);
      wait_valid();
      run_burst(p1, 0, -1, 0, p1);

      // Sign-quantization values (raw unless the feature macro is defined)
      pulse_start(p4);
      wait_valid();
      run_burst(p4, 0, -1, 0, p4);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
